pm_cycle_seq: RTL and testbench

- Parametrised, fully synchronous successor to the P-M cycle-boundary logic: the KC (end of cycle) and PC (start of cycle) univibrators, and the PR (fetch) / PRZERW (interrupt) decision flip-flops.
- Pulse widths are counted in clock ticks rather than produced by analogue univibs.
- Interrupt acceptance is generalised from a single irq line to NIRQ prioritised channels, and the accepted channel number is latched.
- Sits between the microinstruction state logic (which issues end-of-cycle requests) and the P0/P1/I1 state entry strobes.

---
 rtl/pm_cycle_seq.sv | 137 +++++++++++++
 tb/tb_pm_cycle_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pm_cycle_seq.sv
// rtl/pm_cycle_seq.sv - P-M cycle-boundary sequencer: KC/PC pulse timing and PR/PRZERW decision.
// Optional build macro PM_CYCLE_IRQMASK_EN adds a per-channel irq_mask input.
module pm_cycle_seq #(
  parameter int KC_TICKS = 7,
  parameter int PC_TICKS = 6,
  parameter int TICK_W   = 3,
  parameter int NIRQ     = 4,
  parameter int IRQ_W    = 2
) (
  input  logic             __clk,
  input  logic             clm_,
  input  logic             ekc,
  input  logic             run,
  input  logic             cycle,
  input  logic [NIRQ-1:0]  irq,
`ifdef PM_CYCLE_IRQMASK_EN
  input  logic [NIRQ-1:0]  irq_mask,
`endif
  input  logic             irq_en,
  output logic             kc,
  output logic             pc,
  output logic             pr,
  output logic             przerw,
  output logic [IRQ_W-1:0] irq_num,
  output logic             sp0,
  output logic             sp1,
  output logic             si1,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KC   = 2'd1,
    ST_PC   = 2'd2
  } state_t;

  localparam logic [TICK_W-1:0] KC_LOAD = TICK_W'(KC_TICKS - 1);
  localparam logic [TICK_W-1:0] PC_LOAD = TICK_W'(PC_TICKS - 1);

  state_t             state_q, state_d;
  logic [TICK_W-1:0]  cnt_q, cnt_d;
  logic               ekc_pend_q, ekc_pend_d;
  logic               cyc_pend_q, cyc_pend_d;
  logic               pr_q, pr_d;
  logic               przerw_q, przerw_d;
  logic [IRQ_W-1:0]   irq_num_q, irq_num_d;

  logic [NIRQ-1:0]    irq_eff;
  logic [IRQ_W-1:0]   first_idx;
  logic               dec_pr, dec_przerw, cyc_clr;

`ifdef PM_CYCLE_IRQMASK_EN
  assign irq_eff = irq & ~irq_mask;
`else
  assign irq_eff = irq;
`endif

  // Scan from the top so the lowest set bit (highest priority) wins last.
  always_comb begin
    first_idx = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (irq_eff[i]) first_idx = IRQ_W'(i);
    end
  end

  assign dec_przerw = irq_en & (|irq_eff) & (run | cyc_pend_q);
  assign dec_pr     = ~dec_przerw & (run | cyc_pend_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ekc_pend_d = ekc_pend_q | ekc;
    pr_d       = pr_q;
    przerw_d   = przerw_q;
    irq_num_d  = irq_num_q;
    cyc_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ekc | ekc_pend_q) begin
          state_d    = ST_KC;
          cnt_d      = KC_LOAD;
          ekc_pend_d = 1'b0;
        end
      end
      ST_KC: begin
        if (cnt_q == '0) begin
          state_d  = ST_PC;
          cnt_d    = PC_LOAD;
          pr_d     = dec_pr;
          przerw_d = dec_przerw;
          if (dec_przerw) irq_num_d = first_idx;
          cyc_clr  = dec_pr | dec_przerw;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PC: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // A panel request landing on the decision edge survives for the next cycle.
    cyc_pend_d = (cyc_pend_q & ~cyc_clr) | cycle;
  end

  always_ff @(posedge __clk or negedge clm_) begin
    if (!clm_) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ekc_pend_q <= 1'b0;
      cyc_pend_q <= 1'b0;
      pr_q       <= 1'b0;
      przerw_q   <= 1'b0;
      irq_num_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ekc_pend_q <= ekc_pend_d;
      cyc_pend_q <= cyc_pend_d;
      pr_q       <= pr_d;
      przerw_q   <= przerw_d;
      irq_num_q  <= irq_num_d;
    end
  end

  assign kc      = (state_q == ST_KC);
  assign pc      = (state_q == ST_PC);
  assign busy    = (state_q != ST_IDLE);
  assign pr      = pr_q;
  assign przerw  = przerw_q;
  assign irq_num = irq_num_q;
  assign sp0     = pc & ~pr_q & ~przerw_q;
  assign sp1     = pc & pr_q;
  assign si1     = pc & przerw_q;

endmodule

// File: tb/tb_pm_cycle_seq.sv
// tb/tb_pm_cycle_seq.sv - directed and randomized bench for pm_cycle_seq against a pulse-window reference model.
module tb_pm_cycle_seq;

  localparam int KC   = 7;
  localparam int PC   = 6;
  localparam int NIRQ = 4;

  logic       __clk;
  logic       clm_;
  logic       ekc, run, cycle, irq_en;
  logic [3:0] irq, irq_mask;
  logic       kc, pc, pr, przerw, sp0, sp1, si1, busy;
  logic [1:0] irq_num;

  int n_assert = 0;
  int n_fail   = 0;

  pm_cycle_seq dut (
    .__clk   (__clk),
    .clm_    (clm_),
    .ekc     (ekc),
    .run     (run),
    .cycle   (cycle),
    .irq     (irq),
`ifdef PM_CYCLE_IRQMASK_EN
    .irq_mask(irq_mask),
`endif
    .irq_en  (irq_en),
    .kc      (kc),
    .pc      (pc),
    .pr      (pr),
    .przerw  (przerw),
    .irq_num (irq_num),
    .sp0     (sp0),
    .sp1     (sp1),
    .si1     (si1),
    .busy    (busy)
  );

  initial __clk = 1'b0;
  always #5 __clk = ~__clk;

  // Reference model: a burst starting at clock s has KC on [s, s+KC-1] and PC on [s+KC, s+KC+PC-1].
  int         c = 0;
  int         s = -1;
  bit         pend, cpend;
  logic       m_pr, m_przerw;
  logic [1:0] m_num;

  function automatic bit in_burst(int t);
    return (s >= 0) && (t >= s) && (t <= s + KC + PC - 1);
  endfunction

  task automatic model_reset();
    s = -1; pend = 0; cpend = 0;
    m_pr = 0; m_przerw = 0; m_num = 0;
  endtask

  task automatic model_update(input bit i_clm, input bit i_ekc, input bit i_run, input bit i_cyc,
                              input logic [3:0] i_irq, input logic [3:0] i_mask, input bit i_en);
    logic [3:0] eff;
    bit go, found;
    if (!i_clm) begin
      model_reset();
      return;
    end
    if (s >= 0 && c == s + KC) begin
`ifdef PM_CYCLE_IRQMASK_EN
      eff = i_irq & ~i_mask;
`else
      eff = i_irq;
`endif
      go       = i_run | cpend;
      m_przerw = i_en && (eff != 0) && go;
      m_pr     = !m_przerw && go;
      if (m_przerw) begin
        found = 0;
        for (int i = 0; i < NIRQ; i++) begin
          if (!found && eff[i]) begin
            m_num = 2'(i);
            found = 1;
          end
        end
      end
      if (m_pr || m_przerw) cpend = 0;
    end
    if (i_cyc) cpend = 1;
    if (!in_burst(c - 1) && (i_ekc || pend)) begin
      s    = c;
      pend = 0;
    end else if (i_ekc) begin
      pend = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at clock %0d: observed %0h expected %0h", tag, c, obs, exp);
    end
  endtask

  task automatic check_all();
    bit e_kc, e_pc;
    e_kc = (s >= 0) && (c >= s) && (c < s + KC);
    e_pc = (s >= 0) && (c >= s + KC) && (c < s + KC + PC);
    chk("kc",      8'(kc),      8'(e_kc));
    chk("pc",      8'(pc),      8'(e_pc));
    chk("busy",    8'(busy),    8'(e_kc | e_pc));
    chk("pr",      8'(pr),      8'(m_pr));
    chk("przerw",  8'(przerw),  8'(m_przerw));
    chk("irq_num", 8'(irq_num), 8'(m_num));
    chk("sp0",     8'(sp0),     8'(e_pc & ~m_pr & ~m_przerw));
    chk("sp1",     8'(sp1),     8'(e_pc & m_pr));
    chk("si1",     8'(si1),     8'(e_pc & m_przerw));
  endtask

  task automatic tick();
    bit i_clm, i_ekc, i_run, i_cyc, i_en;
    logic [3:0] i_irq, i_mask;
    i_clm = clm_; i_ekc = ekc; i_run = run; i_cyc = cycle;
    i_irq = irq; i_mask = irq_mask; i_en = irq_en;
    @(posedge __clk);
    #1;
    c++;
    model_update(i_clm, i_ekc, i_run, i_cyc, i_irq, i_mask, i_en);
    check_all();
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_ekc();
    ekc = 1'b1;
    tick();
    ekc = 1'b0;
  endtask

  initial begin
    clm_ = 1'b0; ekc = 0; run = 0; cycle = 0; irq_en = 0; irq = '0; irq_mask = '0;
    model_reset();
    run_ticks(3);
    chk("reset_busy", 8'(busy), 8'd0);
    chk("reset_kc",   8'(kc),   8'd0);
    clm_ = 1'b1;
    run_ticks(2);

    // Plain fetch cycle.
    run = 1;
    pulse_ekc();
    chk("t1_kc_c1", 8'(kc), 8'd1);
    run_ticks(7);
    chk("t1_pr_c8",  8'(pr),  8'd1);
    chk("t1_sp1_c8", 8'(sp1), 8'd1);
    run_ticks(6);
    chk("t1_busy_c14", 8'(busy), 8'd0);

    // Interrupt with priority among channels 1 and 3.
    irq_en = 1; irq = 4'b1010;
    pulse_ekc();
    run_ticks(7);
    chk("t2_przerw", 8'(przerw),  8'd1);
    chk("t2_si1",    8'(si1),     8'd1);
    chk("t2_num",    8'(irq_num), 8'd1);
    chk("t2_pr",     8'(pr),      8'd0);
    run_ticks(6);

    // Single-cycle request while stopped, then a plain P0 cycle.
    run = 0; irq = '0; irq_en = 0;
    cycle = 1; tick(); cycle = 0;
    tick();
    pulse_ekc();
    run_ticks(7);
    chk("t3_pr_c10", 8'(pr), 8'd1);
    run_ticks(6);
    pulse_ekc();
    run_ticks(7);
    chk("t3_sp0", 8'(sp0), 8'd1);
    chk("t3_pr",  8'(pr),  8'd0);
    run_ticks(6);

    // ekc during PC is held and restarts after one idle clock.
    run = 1; irq_en = 1; irq = 4'b0100;
    pulse_ekc();
    run_ticks(9);
    ekc = 1; tick(); ekc = 0;
    run_ticks(3);
    chk("t4_busy_c14", 8'(busy), 8'd0);
    tick();
    chk("t4_kc_c15", 8'(kc), 8'd1);
    run_ticks(13);
    chk("t4_num", 8'(irq_num), 8'd2);

    // Asynchronous reset mid-KC.
    pulse_ekc();
    run_ticks(3);
    #2 clm_ = 1'b0;
    #1;
    model_reset();
    chk("t5_kc",     8'(kc),      8'd0);
    chk("t5_busy",   8'(busy),    8'd0);
    chk("t5_przerw", 8'(przerw),  8'd0);
    chk("t5_pr",     8'(pr),      8'd0);
    chk("t5_num",    8'(irq_num), 8'd0);
    run_ticks(2);
    clm_ = 1'b1;
    run_ticks(20);
    chk("t5_no_pulse", 8'(busy), 8'd0);

`ifdef PM_CYCLE_IRQMASK_EN
    run = 1; irq_en = 1; irq = 4'b0011; irq_mask = 4'b0001;
    pulse_ekc();
    run_ticks(7);
    chk("m_num",    8'(irq_num), 8'd1);
    chk("m_przerw", 8'(przerw),  8'd1);
    run_ticks(6);
    irq_mask = 4'b0011;
    pulse_ekc();
    run_ticks(7);
    chk("m_all_przerw", 8'(przerw), 8'd0);
    chk("m_all_pr",     8'(pr),     8'd1);
    run_ticks(6);
    irq_mask = '0;
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      ekc    = ($urandom_range(0, 7) == 0);
      cycle  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) run = $urandom_range(0, 1);
      irq_en = ($urandom_range(0, 3) != 0);
      irq    = 4'($urandom_range(0, 15));
`ifdef PM_CYCLE_IRQMASK_EN
      irq_mask = 4'($urandom_range(0, 15));
`endif
      tick();
    end
    ekc = 0; cycle = 0;
    run_ticks(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
